axi_lsu_rd_resp: RTL and testbench
==================================

// Module: axi_lsu_rd_resp
// PURPOSE
// - AXI-style read responder on the far end of the LSU read initiator: accepts LSU AR requests, reads a local
//   64-bit word memory (DRAM model/bridge), returns R beats to the LSU.
// - Strided 2-D transfers: (arnum+1) rows x (arlen+1) beats; one transaction outstanding; full rrdy backpressure.
// PARAMETERS
// - ADDR_W  10  word-address width; matches lsu_axi_araddr
// - DATA_W  64  beat/word width; matches axi_lsu_rdata
// - FIFO_D  2   response buffer depth; fixed, covers the 1-cycle memory latency
// PORTS
// - clk                  in   1       clock
// - rst_n                in   1       synchronous active-low reset
// - lsu_axi_arid         in   8       request ID
// - lsu_axi_araddr       in   10      start word address
// - lsu_axi_arlen        in   8       beats per row minus 1
// - lsu_axi_arsize       in   3       beat size; only 3'b011 (8 B) legal
// - lsu_axi_arburst      in   2       00 FIXED, 01 INCR, 10/11 illegal
// - lsu_axi_arstr        in   3       row-pitch shift
// - lsu_axi_arnum        in   8       rows minus 1
// - lsu_axi_arvld        in   1       AR valid
// - axi_lsu_arrdy        out  1       AR ready
// - axi_lsu_rid          out  8       latched arid
// - axi_lsu_rdata        out  64      read beat
// - axi_lsu_rresp        out  2       00 OKAY, 10 SLVERR
// - axi_lsu_rlast        out  1       last beat of the whole transaction
// - axi_lsu_rvld         out  1       R valid
// - lsu_axi_rrdy         in   1       R ready
// - mem_rd_en            out  1       memory read strobe
// - mem_rd_addr          out  10     memory word address
// - mem_rd_data          in   64      data, valid exactly 1 cycle after mem_rd_en
// BEHAVIOUR
// - Reset: every output 0, FSM in IDLE, FIFO empty, in-flight flag clear. arrdy registered; it is 1 from the first cycle after rst_n=1.
// - Reset mid-transfer: transaction is dropped and no further beats are sent. The LSU side is reset with this block.
// - FSM: IDLE -> BURST on arvld&&arrdy; BURST -> DRAIN when the last read issues; DRAIN -> IDLE on the cycle the rlast beat handshakes (rvld&&rrdy&&rlast).
// - arrdy = (state==IDLE). On AR accept, latch id/addr/len/num/str/burst and compute resp:
//   - SLVERR if arsize!=3'b011 or arburst[1]=1; otherwise OKAY.
// - Addressing, mod 2^ADDR_W wrap:
//   - row_base(0) = araddr; row_base(r+1) = row_base(r) + ((arlen+1) << arstr).
//   - Beat b of row r: INCR gives row_base(r)+b; FIXED gives row_base(r).
//   - Pitch is computed at 11 bits and truncated to 10.
// - Beat count: total = (arlen+1)*(arnum+1), max 65536. Use a beat counter (8b) and a row counter (8b), not a multiplier.
// - Issue rule: mem_rd_en=1 in BURST only when fifo_cnt + inflight < FIFO_D after counting that cycle's pop.
//   - mem_rd_data enters the FIFO the next cycle, tagged with last = (final beat of final row).
// - SLVERR path: mem_rd_en stays 0. Beats enter the FIFO directly with rdata=0, at the same count and with rlast on the final beat.
// - R channel: rvld = FIFO not empty; rdata/rlast/rresp come from the FIFO head; rid = latched id.
//   - Payload is held stable while rvld&&!rrdy.
//   - Throughput is 1 beat/cycle when rrdy is held at 1. First rvld comes 2 cycles after the AR handshake.
// - Simultaneous push and pop on a full FIFO is legal; count stays the same.
// - Single-beat transfer (arlen=0, arnum=0): rlast on beat 0.
// - No new AR is accepted until the rlast beat handshakes. arvld held in BURST/DRAIN is ignored.
// STRUCTURE
// - Package axi_rd_pkg:
//   - BURST_FIXED/INCR, RESP_OKAY/SLVERR, SIZE_8B
//   - typedef enum {IDLE,BURST,DRAIN} rd_state_t
//   - typedef struct {data, last} rd_beat_t
// - Sub-module rd_resp_fifo: 2-entry synchronous FIFO of rd_beat_t with push/pop/full/empty/count.
// TESTING
// - AR id=8'h5A addr=0 len=3 num=0 INCR size=3, rrdy=1 -> 4 beats mem[0..3], rid=5A, rresp=00, rlast on beat 3 only.
// - len=1 num=2 str=1 addr=10 -> addresses 10,11,14,15,18,19; rlast on 6th beat; arrdy=0 until then.
// - FIXED addr=7 len=2 -> 3 beats all mem[7]. addr=1020 len=7 INCR -> wraps to 1020..1023,0..3.
// - arsize=3'b010 len=1 -> 2 beats rdata=0 rresp=10, mem_rd_en never asserted.
// - rrdy toggling 1,0,0,1,... over len=7 -> no beat lost or duplicated, payload stable while stalled, mem_rd_en never pushes past 2 entries.
// - rst_n=0 for 1 cycle during beat 2 of len=7 -> next cycle all outputs 0; arrdy=1 the cycle after; a new AR then completes cleanly.

Source files
------------

// File: rtl/axi_rd_pkg.sv
// Shared encodings and types for the LSU read responder.
package axi_rd_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_8B     = 3'b011;
    localparam int         RD_DATA_W   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [RD_DATA_W-1:0] data;
        logic                 last;
    } rd_beat_t;

endpackage

// File: rtl/rd_resp_fifo.sv
// Two-entry synchronous response buffer between memory return and the R channel.
module rd_resp_fifo
    import axi_rd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rd_beat_t   push_beat,
    input  logic       pop,
    output rd_beat_t   head,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    rd_beat_t   mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;

    // Pointer and occupancy update; simultaneous push and pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Control state, cleared on reset so the buffer comes up empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_beat;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign count = cnt_q;

endmodule

// File: rtl/axi_lsu_rd_resp.sv
// AXI-style read responder: serves strided 2-D read bursts from a local word memory.
module axi_lsu_rd_resp
    import axi_rd_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int FIFO_D = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        lsu_axi_arid,
    input  logic [ADDR_W-1:0] lsu_axi_araddr,
    input  logic [7:0]        lsu_axi_arlen,
    input  logic [2:0]        lsu_axi_arsize,
    input  logic [1:0]        lsu_axi_arburst,
    input  logic [2:0]        lsu_axi_arstr,
    input  logic [7:0]        lsu_axi_arnum,
    input  logic              lsu_axi_arvld,
    output logic              axi_lsu_arrdy,
    output logic [7:0]        axi_lsu_rid,
    output logic [DATA_W-1:0] axi_lsu_rdata,
    output logic [1:0]        axi_lsu_rresp,
    output logic              axi_lsu_rlast,
    output logic              axi_lsu_rvld,
    input  logic              lsu_axi_rrdy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
);

    rd_state_t         state_q, state_d;
    logic              arrdy_q, arrdy_d;
    logic [7:0]        id_q, id_d;
    logic              err_q, err_d;
    logic [7:0]        beat_q, beat_d, row_q, row_d;
    logic              inflight_q, inflight_d;
    logic              infl_last_q, infl_last_d;
    logic [7:0]        len_q, len_d, num_q, num_d;
    logic              incr_q, incr_d;
    logic [ADDR_W-1:0] addr_q, addr_d, row_base_q, row_base_d, pitch_q, pitch_d;

    logic [ADDR_W:0]   pitch_full;
    logic [2:0]        occ_after_pop;
    logic              ar_hs, issue, last_beat, last_row;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]        fifo_cnt;
    rd_beat_t          push_beat, head_beat;

    // Row pitch is formed one bit wider than the address, then wraps with it.
    assign pitch_full = ((ADDR_W+1)'(lsu_axi_arlen) + (ADDR_W+1)'(1)) << lsu_axi_arstr;

    assign ar_hs         = lsu_axi_arvld && arrdy_q;
    assign axi_lsu_rvld  = !fifo_empty;
    assign fifo_pop      = axi_lsu_rvld && lsu_axi_rrdy;
    assign occ_after_pop = 3'(fifo_cnt) + 3'(inflight_q) - 3'(fifo_pop);
    assign issue         = (state_q == BURST) && (occ_after_pop < 3'(FIFO_D));
    assign last_beat     = (beat_q == len_q);
    assign last_row      = (row_q == num_q);

    // Next-state, address walk and request latching.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        err_d      = err_q;
        beat_d     = beat_q;
        row_d      = row_q;
        len_d      = len_q;
        num_d      = num_q;
        incr_d     = incr_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        pitch_d    = pitch_q;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    id_d       = lsu_axi_arid;
                    err_d      = (lsu_axi_arsize != SIZE_8B) || lsu_axi_arburst[1];
                    len_d      = lsu_axi_arlen;
                    num_d      = lsu_axi_arnum;
                    incr_d     = (lsu_axi_arburst == BURST_INCR);
                    addr_d     = lsu_axi_araddr;
                    row_base_d = lsu_axi_araddr;
                    pitch_d    = pitch_full[ADDR_W-1:0];
                    beat_d     = 8'd0;
                    row_d      = 8'd0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (issue) begin
                    if (last_beat) begin
                        beat_d = 8'd0;
                        if (last_row) begin
                            state_d = DRAIN;
                        end else begin
                            row_d      = row_q + 8'd1;
                            row_base_d = row_base_q + pitch_q;
                            addr_d     = row_base_q + pitch_q;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                        if (incr_q) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (fifo_pop && head_beat.last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        arrdy_d     = (state_d == IDLE);
        inflight_d  = issue;
        infl_last_d = issue && last_beat && last_row;
    end

    // Control registers; reset drops any transaction in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            arrdy_q     <= 1'b0;
            id_q        <= 8'd0;
            err_q       <= 1'b0;
            beat_q      <= 8'd0;
            row_q       <= 8'd0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arrdy_q     <= arrdy_d;
            id_q        <= id_d;
            err_q       <= err_d;
            beat_q      <= beat_d;
            row_q       <= row_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
        end
    end

    // Datapath registers; only meaningful while a transaction is active.
    always_ff @(posedge clk) begin
        len_q      <= len_d;
        num_q      <= num_d;
        incr_q     <= incr_d;
        addr_q     <= addr_d;
        row_base_q <= row_base_d;
        pitch_q    <= pitch_d;
    end

    // Error transactions still walk the issue slot so beat count and timing match, but never touch memory.
    assign mem_rd_en      = issue && !err_q;
    assign mem_rd_addr    = mem_rd_en ? addr_q : '0;
    assign fifo_push      = inflight_q && (!fifo_full || fifo_pop);
    assign push_beat.data = err_q ? '0 : mem_rd_data;
    assign push_beat.last = infl_last_q;

    rd_resp_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_beat (push_beat),
        .pop       (fifo_pop),
        .head      (head_beat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign axi_lsu_arrdy = arrdy_q;
    assign axi_lsu_rid   = id_q;
    assign axi_lsu_rdata = axi_lsu_rvld ? head_beat.data : '0;
    assign axi_lsu_rlast = axi_lsu_rvld && head_beat.last;
    assign axi_lsu_rresp = (axi_lsu_rvld && err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_lsu_rd_resp.sv
// Directed bench for axi_lsu_rd_resp: vector table of AR requests plus reset corner cases.
module tb_axi_lsu_rd_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  arid;
    logic [9:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [2:0]  arstr;
    logic [7:0]  arnum;
    logic        arvld;
    logic        arrdy;
    logic [7:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvld;
    logic        rrdy;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [63:0] mem_rd_data = 64'd0;

    int checks   = 0;
    int failures = 0;

    axi_lsu_rd_resp dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lsu_axi_arid    (arid),
        .lsu_axi_araddr  (araddr),
        .lsu_axi_arlen   (arlen),
        .lsu_axi_arsize  (arsize),
        .lsu_axi_arburst (arburst),
        .lsu_axi_arstr   (arstr),
        .lsu_axi_arnum   (arnum),
        .lsu_axi_arvld   (arvld),
        .axi_lsu_arrdy   (arrdy),
        .axi_lsu_rid     (rid),
        .axi_lsu_rdata   (rdata),
        .axi_lsu_rresp   (rresp),
        .axi_lsu_rlast   (rlast),
        .axi_lsu_rvld    (rvld),
        .lsu_axi_rrdy    (rrdy),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] memval(input logic [9:0] a);
        return {16'hBEEF, 6'h0, a, 16'hF00D, 6'h0, ~a};
    endfunction

    // Memory model: data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= memval(mem_rd_addr);
        else           mem_rd_data <= 64'hDEAD_DEAD_DEAD_DEAD;
    end

    typedef struct packed {
        logic [7:0]       id;
        logic [9:0]       addr;
        logic [7:0]       len;
        logic [7:0]       num;
        logic [2:0]       str;
        logic [1:0]       burst;
        logic [2:0]       size;
        logic [1:0]       mode;
        logic             hold;
        logic [1:0]       resp;
        logic [3:0]       n;
        logic [7:0][9:0]  ea;
    } vec_t;

    vec_t vt [9];

    function automatic vec_t mk(input int id, input int addr, input int len, input int num,
                                input int str, input int burst, input int size, input int mode,
                                input int hold, input int resp, input int n,
                                input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7);
        vec_t v;
        v.id = 8'(id); v.addr = 10'(addr); v.len = 8'(len); v.num = 8'(num);
        v.str = 3'(str); v.burst = 2'(burst); v.size = 3'(size); v.mode = 2'(mode);
        v.hold = 1'(hold); v.resp = 2'(resp); v.n = 4'(n);
        v.ea[0] = 10'(a0); v.ea[1] = 10'(a1); v.ea[2] = 10'(a2); v.ea[3] = 10'(a3);
        v.ea[4] = 10'(a4); v.ea[5] = 10'(a5); v.ea[6] = 10'(a6); v.ea[7] = 10'(a7);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_arrdy"}, 64'(arrdy), 64'd0);
        chk({tag, "_rvld"},  64'(rvld),  64'd0);
        chk({tag, "_rdata"}, rdata,      64'd0);
        chk({tag, "_rlast"}, 64'(rlast), 64'd0);
        chk({tag, "_rresp"}, 64'(rresp), 64'd0);
        chk({tag, "_rid"},   64'(rid),   64'd0);
        chk({tag, "_memen"}, 64'(mem_rd_en),   64'd0);
        chk({tag, "_memad"}, 64'(mem_rd_addr), 64'd0);
    endtask

    task automatic send_ar(input vec_t v, output logic ok);
        int w = 0;
        @(negedge clk);
        arid = v.id; araddr = v.addr; arlen = v.len; arnum = v.num;
        arstr = v.str; arburst = v.burst; arsize = v.size; arvld = 1'b1;
        #1;
        while (!arrdy && w < 20) begin
            @(negedge clk); #1; w++;
        end
        ok = arrdy;
        chk("arrdy_before_ar", 64'(arrdy), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input int vi);
        vec_t v = vt[vi];
        logic err = (v.resp == 2'b10);
        logic ok, done = 1'b0, held_valid = 1'b0, held_last = 1'b0;
        logic [63:0] held_data = 64'd0, expd;
        int cyc = 0, k = 0, issued = 0, popped = 0, first = -1;
        int addr_bad = 0, arrdy_bad = 0, stall_bad = 0, occ_bad = 0;
        string tg = $sformatf("v%0d", vi);
        send_ar(v, ok);
        if (v.hold) begin
            arid = 8'hEE; araddr = 10'h3FF; arlen = 8'd0;
        end else begin
            arvld = 1'b0;
        end
        while (ok && !done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            rrdy = (v.mode == 2'd0) ? 1'b1 : (((cyc - 1) % 3) == 0);
            #1;
            if (rvld && first < 0) first = cyc;
            if (mem_rd_en) begin
                if (issued < 8 && mem_rd_addr !== v.ea[issued]) addr_bad++;
                issued++;
            end
            if (arrdy) arrdy_bad++;
            if (held_valid && (!rvld || rdata !== held_data || rlast !== held_last)) stall_bad++;
            held_valid = 1'b0;
            if (rvld) begin
                if (rrdy) begin
                    expd = err ? 64'd0 : memval(v.ea[k[2:0]]);
                    chk($sformatf("%s_b%0d_data", tg, k), rdata, expd);
                    chk($sformatf("%s_b%0d_last", tg, k), 64'(rlast), 64'(k == v.n - 1));
                    chk($sformatf("%s_b%0d_resp", tg, k), 64'(rresp), 64'(v.resp));
                    chk($sformatf("%s_b%0d_rid", tg, k), 64'(rid), 64'(v.id));
                    k++;
                    popped++;
                    if (k == int'(v.n)) done = 1'b1;
                end else begin
                    held_valid = 1'b1;
                    held_data  = rdata;
                    held_last  = rlast;
                end
            end
            if (issued - popped > 2) occ_bad++;
        end
        chk({tg, "_complete"},   64'(done), 64'd1);
        chk({tg, "_latency"},    64'(first - 1), 64'd2);
        chk({tg, "_issues"},     64'(issued), err ? 64'd0 : 64'(v.n));
        chk({tg, "_addr_seq"},   64'(addr_bad), 64'd0);
        chk({tg, "_arrdy_busy"}, 64'(arrdy_bad), 64'd0);
        chk({tg, "_stall_hold"}, 64'(stall_bad), 64'd0);
        chk({tg, "_occupancy"},  64'(occ_bad), 64'd0);
        @(negedge clk);
        rrdy = 1'b1;
        #1;
        chk({tg, "_no_extra"},   64'(rvld), 64'd0);
        chk({tg, "_arrdy_back"}, 64'(arrdy), 64'd1);
        arvld = 1'b0;
    endtask

    // Reset asserted for one cycle while beat 2 of an 8-beat burst is on the bus.
    task automatic run_mid_reset();
        vec_t v = mk(8'h99, 200, 7, 0, 0, 1, 3, 0, 0, 0, 8, 200, 201, 202, 203, 204, 205, 206, 207);
        logic ok, hit = 1'b0;
        int cyc = 0, k = 0, late = 0;
        send_ar(v, ok);
        arvld = 1'b0;
        while (ok && !hit && cyc < 50) begin
            @(negedge clk);
            cyc++;
            rrdy = 1'b1;
            #1;
            if (rvld) begin
                if (k == 2) begin
                    rst_n = 1'b0;
                    hit = 1'b1;
                end
                k++;
            end
        end
        chk("rst_reached_beat2", 64'(hit), 64'd1);
        @(negedge clk); #1;
        chk_all_zero("rst_mid");
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_mid_arrdy_after", 64'(arrdy), 64'd1);
        for (int i = 0; i < 6; i++) begin
            if (rvld || mem_rd_en) late++;
            @(negedge clk); #1;
        end
        chk("rst_mid_no_beats", 64'(late), 64'd0);
    endtask

    initial begin
        vt[0] = mk(8'h5A,    0, 3, 0, 0, 1, 3,     0, 0, 0, 4,    0,    1,    2,    3,  0,  0,  0,  0);
        vt[1] = mk(8'h11,   10, 1, 2, 1, 1, 3,     0, 1, 0, 6,   10,   11,   14,   15, 18, 19,  0,  0);
        vt[2] = mk(8'h22,    7, 2, 0, 0, 0, 3,     0, 0, 0, 3,    7,    7,    7,    0,  0,  0,  0,  0);
        vt[3] = mk(8'h33, 1020, 7, 0, 0, 1, 3,     0, 0, 0, 8, 1020, 1021, 1022, 1023,  0,  1,  2,  3);
        vt[4] = mk(8'h44,    5, 1, 0, 0, 1, 3'b010, 0, 0, 2, 2,   0,    0,    0,    0,  0,  0,  0,  0);
        vt[5] = mk(8'h55,  100, 7, 0, 0, 1, 3,     1, 0, 0, 8,  100,  101,  102,  103, 104, 105, 106, 107);
        vt[6] = mk(8'h66,  500, 0, 0, 0, 1, 3,     0, 0, 0, 1,  500,    0,    0,    0,  0,  0,  0,  0);
        vt[7] = mk(8'h77,   30, 0, 0, 0, 2, 3,     1, 0, 2, 1,    0,    0,    0,    0,  0,  0,  0,  0);
        vt[8] = mk(8'h88,   20, 1, 1, 2, 0, 3,     1, 0, 0, 4,   20,   20,   28,   28,  0,  0,  0,  0);

        rst_n = 1'b0; arvld = 1'b0; rrdy = 1'b0;
        arid = 8'd0; araddr = 10'd0; arlen = 8'd0; arsize = 3'd3;
        arburst = 2'd1; arstr = 3'd0; arnum = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("reset_arrdy_first", 64'(arrdy), 64'd1);

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
        end

        run_mid_reset();
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
